// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control block: opcodes, control
// bundle layout, forwarding and PC-select codes.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // EX bundle {reg_dst, alu_op[1:0], alu_src}
  localparam int EX_REG_DST   = 3;
  localparam int EX_ALU_OP_HI = 2;
  localparam int EX_ALU_OP_LO = 1;
  localparam int EX_ALU_SRC   = 0;

  // MEM bundle {branch, mem_read, mem_write}
  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  // WB bundle {reg_write, mem_to_reg}
  localparam int WB_REG_WRITE  = 1;
  localparam int WB_MEM_TO_REG = 0;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational hazard detection (load-use, branch operand) and ALU operand
// forwarding selects, driven purely from ID fields and stage registers.
module pipe_hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_id,
  input  logic [RA_W-1:0] rt_id,
  input  logic            rt_src_id,
  input  logic            branch_id,
  input  logic            idex_mem_read,
  input  logic            idex_reg_write,
  input  logic [RA_W-1:0] idex_dest,
  input  logic [RA_W-1:0] idex_rs,
  input  logic [RA_W-1:0] idex_rt,
  input  logic            exmem_mem_read,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_dest,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_dest,
  output logic            stall,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  logic idex_live;
  logic exmem_live;
  logic memwb_live;
  logic idex_hits_id;
  logic exmem_hits_id;
  logic load_use;
  logic branch_on_ex;
  logic branch_on_load;

  // r0 is hardwired, so a write to it can never create a dependency
  assign idex_live  = (idex_dest != '0);
  assign exmem_live = (exmem_dest != '0);
  assign memwb_live = (memwb_dest != '0);

  assign idex_hits_id  = (idex_dest == rs_id) || (idex_dest == rt_id);
  assign exmem_hits_id = (exmem_dest == rs_id) || (exmem_dest == rt_id);

  assign load_use = idex_mem_read && idex_live &&
                    ((idex_dest == rs_id) || (rt_src_id && (idex_dest == rt_id)));

  // Branches compare in ID, so they must wait for ALU results and loads alike
  assign branch_on_ex   = branch_id && idex_reg_write && idex_live && idex_hits_id;
  assign branch_on_load = branch_id && exmem_mem_read && exmem_live && exmem_hits_id;

  assign stall = load_use || branch_on_ex || branch_on_load;

  function automatic logic [1:0] fwd_pick(input logic [RA_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (exmem_reg_write && exmem_live && (exmem_dest == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && memwb_live && (memwb_dest == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_pick(idex_rs);
  assign fwd_b = fwd_pick(idex_rt);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// MIPS pipeline control: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// bubble insertion, branch/jump redirect, illegal-opcode flag, stall counter.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16,
  parameter int EN_BNE  = 1,
  parameter int EN_JUMP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode_id,
  input  logic [RA_W-1:0]  rs_id,
  input  logic [RA_W-1:0]  rt_id,
  input  logic [RA_W-1:0]  rd_id,
  input  logic             br_eq_id,
  input  logic             hold,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic [1:0]       pc_sel,
  output logic [EX_W-1:0]  ex_ctrl,
  output logic [MEM_W-1:0] mem_ctrl,
  output logic [WB_W-1:0]  wb_ctrl,
  output logic [RA_W-1:0]  exmem_dest,
  output logic [RA_W-1:0]  memwb_dest,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t            dec;
  logic             illegal_id;
  logic             rt_src_id;
  logic             is_beq;
  logic             is_bne;
  logic             is_j;
  logic [RA_W-1:0]  dest_id;

  ctrl_t            idex_ctrl;
  logic [RA_W-1:0]  idex_dest;
  logic [RA_W-1:0]  idex_rs;
  logic [RA_W-1:0]  idex_rt;
  logic [MEM_W-1:0] exmem_mem;
  logic [WB_W-1:0]  exmem_wb;
  logic [RA_W-1:0]  exmem_dest_q;
  logic [WB_W-1:0]  memwb_wb;
  logic [RA_W-1:0]  memwb_dest_q;
  logic             illegal_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             stall;
  logic             advance;
  logic             taken;

  always_comb begin
    dec        = CTRL_NONE;
    illegal_id = 1'b0;
    rt_src_id  = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    case (opcode_id)
      OP_W'(OP_RTYPE): begin
        dec.ex[EX_REG_DST]                = 1'b1;
        dec.ex[EX_ALU_OP_HI:EX_ALU_OP_LO] = ALU_OP_FUNCT;
        dec.wb[WB_REG_WRITE]              = 1'b1;
        rt_src_id                         = 1'b1;
      end
      OP_W'(OP_LW): begin
        dec.ex[EX_ALU_SRC]    = 1'b1;
        dec.mem[MEM_READ]     = 1'b1;
        dec.wb[WB_REG_WRITE]  = 1'b1;
        dec.wb[WB_MEM_TO_REG] = 1'b1;
      end
      OP_W'(OP_SW): begin
        dec.ex[EX_ALU_SRC] = 1'b1;
        dec.mem[MEM_WRITE] = 1'b1;
        rt_src_id          = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        dec.ex[EX_ALU_OP_HI:EX_ALU_OP_LO] = ALU_OP_SUB;
        dec.mem[MEM_BRANCH]               = 1'b1;
        rt_src_id                         = 1'b1;
        is_beq                            = 1'b1;
      end
      OP_W'(OP_BNE): begin
        if (EN_BNE != 0) begin
          dec.ex[EX_ALU_OP_HI:EX_ALU_OP_LO] = ALU_OP_SUB;
          dec.mem[MEM_BRANCH]               = 1'b1;
          rt_src_id                         = 1'b1;
          is_bne                            = 1'b1;
        end else begin
          illegal_id = 1'b1;
        end
      end
      OP_W'(OP_ADDI): begin
        dec.ex[EX_ALU_SRC]   = 1'b1;
        dec.wb[WB_REG_WRITE] = 1'b1;
      end
      OP_W'(OP_J): begin
        if (EN_JUMP != 0) begin
          is_j = 1'b1;
        end else begin
          illegal_id = 1'b1;
        end
      end
      default: illegal_id = 1'b1;
    endcase
  end

  assign dest_id = dec.ex[EX_REG_DST] ? rd_id : rt_id;

  pipe_hazard_unit #(
    .RA_W(RA_W)
  ) u_hazard (
    .rs_id          (rs_id),
    .rt_id          (rt_id),
    .rt_src_id      (rt_src_id),
    .branch_id      (is_beq || is_bne),
    .idex_mem_read  (idex_ctrl.mem[MEM_READ]),
    .idex_reg_write (idex_ctrl.wb[WB_REG_WRITE]),
    .idex_dest      (idex_dest),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .exmem_mem_read (exmem_mem[MEM_READ]),
    .exmem_reg_write(exmem_wb[WB_REG_WRITE]),
    .exmem_dest     (exmem_dest_q),
    .memwb_reg_write(memwb_wb[WB_REG_WRITE]),
    .memwb_dest     (memwb_dest_q),
    .stall          (stall),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ctrl    <= CTRL_NONE;
      idex_dest    <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      exmem_mem    <= '0;
      exmem_wb     <= '0;
      exmem_dest_q <= '0;
      memwb_wb     <= '0;
      memwb_dest_q <= '0;
      illegal_q    <= 1'b0;
      stall_cnt_q  <= '0;
    end else if (hold) begin
      // Frozen pipeline; a held cycle never reports an illegal opcode
      illegal_q <= 1'b0;
    end else begin
      exmem_mem    <= idex_ctrl.mem;
      exmem_wb     <= idex_ctrl.wb;
      exmem_dest_q <= idex_dest;
      memwb_wb     <= exmem_wb;
      memwb_dest_q <= exmem_dest_q;
      // The stalled instruction stays in ID and is flagged when it advances
      illegal_q    <= illegal_id && !stall;
      if (stall) begin
        idex_ctrl <= CTRL_NONE;
        idex_dest <= '0;
        idex_rs   <= '0;
        idex_rt   <= '0;
        if (stall_cnt_q != '1) begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
      end else begin
        idex_ctrl <= dec;
        idex_dest <= dest_id;
        idex_rs   <= rs_id;
        idex_rt   <= rt_id;
      end
    end
  end

  assign advance = !reset && !hold && !stall;
  assign taken   = (is_beq && br_eq_id) || (is_bne && !br_eq_id);

  assign pc_write   = advance;
  assign ifid_write = advance;
  assign if_flush   = advance && (taken || is_j);

  always_comb begin
    pc_sel = PC_PLUS4;
    if (advance) begin
      if (is_j) begin
        pc_sel = PC_JUMP;
      end else if (taken) begin
        pc_sel = PC_BRANCH;
      end
    end
  end

  assign ex_ctrl     = idex_ctrl.ex;
  assign mem_ctrl    = exmem_mem;
  assign wb_ctrl     = memwb_wb;
  assign exmem_dest  = exmem_dest_q;
  assign memwb_dest  = memwb_dest_q;
  assign illegal_op  = illegal_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: instruction-level pipeline model checked every
// cycle, plus directed literal expectations; a CNT_W=2 copy shows saturation.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] RT   = 6'h00;
  localparam logic [5:0] J    = 6'h02;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] BNE  = 6'h05;
  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2b;
  localparam logic [5:0] BAD  = 6'h3f;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id, rd_id;
  logic       br_eq_id, hold;

  logic        pc_write, ifid_write, if_flush, illegal_op;
  logic [1:0]  pc_sel, fwd_a, fwd_b, wb_ctrl;
  logic [3:0]  ex_ctrl;
  logic [2:0]  mem_ctrl;
  logic [4:0]  exmem_dest, memwb_dest;
  logic [15:0] stall_count;

  logic        pc_write_s, ifid_write_s, if_flush_s, illegal_op_s;
  logic [1:0]  pc_sel_s, fwd_a_s, fwd_b_s, wb_ctrl_s;
  logic [3:0]  ex_ctrl_s;
  logic [2:0]  mem_ctrl_s;
  logic [4:0]  exmem_dest_s, memwb_dest_s;
  logic [1:0]  stall_count_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_id(rd_id), .br_eq_id(br_eq_id), .hold(hold), .pc_write(pc_write),
    .ifid_write(ifid_write), .if_flush(if_flush), .pc_sel(pc_sel), .ex_ctrl(ex_ctrl),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .exmem_dest(exmem_dest),
    .memwb_dest(memwb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal_op(illegal_op),
    .stall_count(stall_count)
  );

  pipe_ctrl_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
    .rd_id(rd_id), .br_eq_id(br_eq_id), .hold(hold), .pc_write(pc_write_s),
    .ifid_write(ifid_write_s), .if_flush(if_flush_s), .pc_sel(pc_sel_s),
    .ex_ctrl(ex_ctrl_s), .mem_ctrl(mem_ctrl_s), .wb_ctrl(wb_ctrl_s),
    .exmem_dest(exmem_dest_s), .memwb_dest(memwb_dest_s), .fwd_a(fwd_a_s),
    .fwd_b(fwd_b_s), .illegal_op(illegal_op_s), .stall_count(stall_count_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct {
    bit         v;
    logic [5:0] op;
    logic [4:0] rs, rt, dest;
  } ins_t;

  typedef struct {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    bit         legal;
    bit         rt_src;
  } info_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_stalls;
  bit   m_ill;
  bit   m_ok = 0;

  function automatic info_t info(input logic [5:0] op);
    info_t r;
    r.ex = 4'b0; r.mem = 3'b0; r.wb = 2'b0; r.legal = 1; r.rt_src = 0;
    case (op)
      RT:       begin r.ex = 4'b1100; r.wb = 2'b10; r.rt_src = 1; end
      LW:       begin r.ex = 4'b0001; r.mem = 3'b010; r.wb = 2'b11; end
      SW:       begin r.ex = 4'b0001; r.mem = 3'b001; r.rt_src = 1; end
      BEQ, BNE: begin r.ex = 4'b0010; r.mem = 3'b100; r.rt_src = 1; end
      ADDI:     begin r.ex = 4'b0001; r.wb = 2'b10; end
      J:        ;
      default:  r.legal = 0;
    endcase
    return r;
  endfunction

  function automatic ins_t bubble();
    ins_t b;
    b.v = 0; b.op = 6'h0; b.rs = 5'h0; b.rt = 5'h0; b.dest = 5'h0;
    return b;
  endfunction

  function automatic ins_t id_rec();
    ins_t r;
    info_t f;
    f = info(opcode_id);
    r.v = 1; r.op = opcode_id; r.rs = rs_id; r.rt = rt_id;
    r.dest = f.ex[3] ? rd_id : rt_id;
    return r;
  endfunction

  function automatic bit writes(input ins_t i);
    info_t f;
    f = info(i.op);
    return i.v && f.wb[1] && (i.dest != 0);
  endfunction

  function automatic bit loads(input ins_t i);
    info_t f;
    f = info(i.op);
    return i.v && f.mem[1] && (i.dest != 0);
  endfunction

  function automatic bit model_stall();
    info_t f;
    bit is_br, lu, bh;
    f = info(opcode_id);
    is_br = (opcode_id == BEQ) || (opcode_id == BNE);
    lu = loads(m_ex) && ((m_ex.dest == rs_id) || (f.rt_src && m_ex.dest == rt_id));
    bh = is_br && ((writes(m_ex) && (m_ex.dest == rs_id || m_ex.dest == rt_id)) ||
                   (loads(m_mem) && (m_mem.dest == rs_id || m_mem.dest == rt_id)));
    return lu || bh;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (writes(m_mem) && m_mem.dest == src) return 2'b10;
    if (writes(m_wb) && m_wb.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin : model_step
    bit    st;
    info_t f;
    if (reset) begin
      m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
      m_stalls = 0; m_ill = 0; m_ok = 1;
    end else if (hold) begin
      m_ill = 0;
    end else begin
      st = model_stall();
      f = info(opcode_id);
      m_ill = !f.legal && !st;
      m_wb = m_mem;
      m_mem = m_ex;
      if (st) begin
        m_ex = bubble();
        m_stalls++;
      end else begin
        m_ex = id_rec();
      end
    end
  end

  always @(negedge clk) begin : compare
    bit    st, go, tk;
    info_t fe, fm, fw;
    if (m_ok) begin
      st = model_stall();
      go = !reset && !hold && !st;
      tk = (opcode_id == BEQ && br_eq_id) || (opcode_id == BNE && !br_eq_id);
      fe = info(m_ex.op); fm = info(m_mem.op); fw = info(m_wb.op);
      chk("m_pc_write", pc_write, go);
      chk("m_ifid_write", ifid_write, go);
      chk("m_if_flush", if_flush, go && (tk || opcode_id == J));
      chk("m_pc_sel", pc_sel, !go ? 2'b00 : (opcode_id == J) ? 2'b10 : tk ? 2'b01 : 2'b00);
      chk("m_ex_ctrl", ex_ctrl, m_ex.v ? fe.ex : 4'b0);
      chk("m_mem_ctrl", mem_ctrl, m_mem.v ? fm.mem : 3'b0);
      chk("m_wb_ctrl", wb_ctrl, m_wb.v ? fw.wb : 2'b0);
      chk("m_exmem_dest", exmem_dest, m_mem.dest);
      chk("m_memwb_dest", memwb_dest, m_wb.dest);
      chk("m_fwd_a", fwd_a, model_fwd(m_ex.rs));
      chk("m_fwd_b", fwd_b, model_fwd(m_ex.rt));
      chk("m_illegal_op", illegal_op, m_ill);
      chk("m_stall_count", stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
      chk("m_stall_count_sat", stall_count_s, (m_stalls > 3) ? 3 : m_stalls);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic beq = 1'b0, input logic hld = 1'b0);
    @(posedge clk);
    #1;
    opcode_id = op; rs_id = rs; rt_id = rt; rd_id = rd; br_eq_id = beq; hold = hld;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode_id = RT; rs_id = 0; rt_id = 0; rd_id = 0; br_eq_id = 0; hold = 0;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_pc_write", pc_write, 0);
    chk("rst_if_flush", if_flush, 0);
    chk("rst_ex_ctrl", ex_ctrl, 4'b0000);
    chk("rst_wb_ctrl", wb_ctrl, 2'b00);
    chk("rst_stall_count", stall_count, 0);

    drive(RT, 1, 2, 4);
    reset = 1'b0;
    drive(RT, 0, 0, 0);
    settle();
    chk("rel_ex_ctrl", ex_ctrl, 4'b1100);

    // load-use: LW r5 then ADD using r5
    drive(LW, 0, 5, 0);
    drive(RT, 5, 6, 7);
    settle();
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    drive(RT, 5, 6, 7);
    settle();
    chk("lu_bubble", ex_ctrl, 4'b0000);
    chk("lu_count", stall_count, 1);
    drive(RT, 0, 0, 0);
    settle();
    chk("lu_add_ex", ex_ctrl, 4'b1100);
    chk("lu_fwd_a", fwd_a, 2'b01);

    // ALU forwarding, then r0 never forwards
    drive(RT, 1, 2, 3);
    drive(RT, 3, 3, 8);
    drive(RT, 0, 0, 0);
    settle();
    chk("alu_fwd_a", fwd_a, 2'b10);
    chk("alu_fwd_b", fwd_b, 2'b10);
    drive(RT, 1, 2, 0);
    drive(RT, 0, 0, 9);
    drive(RT, 0, 0, 0);
    settle();
    chk("r0_fwd_a", fwd_a, 2'b00);

    // branch / jump resolution
    drive(BEQ, 1, 2, 0, 1'b1);
    settle();
    chk("beq_flush", if_flush, 1);
    chk("beq_pc_sel", pc_sel, 2'b01);
    drive(BNE, 1, 2, 0, 1'b1);
    settle();
    chk("bne_flush", if_flush, 0);
    chk("bne_pc_sel", pc_sel, 2'b00);
    drive(J, 0, 0, 0);
    settle();
    chk("j_pc_sel", pc_sel, 2'b10);
    chk("j_flush", if_flush, 1);

    // branch operand hazard on an ALU result
    drive(ADDI, 1, 7, 0);
    drive(BEQ, 7, 2, 0, 1'b1);
    settle();
    chk("bh_flush_supp", if_flush, 0);
    chk("bh_pc_sel_supp", pc_sel, 2'b00);
    drive(BEQ, 7, 2, 0, 1'b1);
    settle();
    chk("bh_flush_after", if_flush, 1);
    chk("bh_count", stall_count, 2);

    // branch on a load: two stalls, hold frozen in between
    drive(LW, 1, 7, 0);
    drive(BEQ, 7, 2, 0, 1'b1);
    settle();
    chk("bl_pc_write", pc_write, 0);
    for (int i = 0; i < 3; i++) begin
      drive(BEQ, 7, 2, 0, 1'b1, 1'b1);
      settle();
      chk("hold_count", stall_count, 3);
      chk("hold_mem_ctrl", mem_ctrl, 3'b010);
      chk("hold_exmem_dest", exmem_dest, 7);
      chk("hold_pc_write", pc_write, 0);
    end
    drive(BEQ, 7, 2, 0, 1'b1);
    settle();
    chk("bl_flush_supp", if_flush, 0);
    drive(BEQ, 7, 2, 0, 1'b1);
    settle();
    chk("bl_flush_after", if_flush, 1);
    chk("bl_count", stall_count, 4);
    chk("bl_wb_ctrl", wb_ctrl, 2'b11);

    // illegal opcode
    drive(BAD, 1, 2, 3);
    settle();
    chk("ill_before", illegal_op, 0);
    drive(RT, 0, 0, 0);
    settle();
    chk("ill_pulse", illegal_op, 1);
    chk("ill_bundle", ex_ctrl, 4'b0000);
    drive(RT, 0, 0, 0);
    settle();
    chk("ill_after", illegal_op, 0);

    // fifth stall, saturation of the narrow counter
    drive(LW, 0, 5, 0);
    drive(RT, 5, 6, 7);
    drive(RT, 5, 6, 7);
    drive(RT, 0, 0, 0);
    settle();
    chk("sat_count16", stall_count, 5);
    chk("sat_count2", stall_count_s, 3);

    // SW reads rt; ADDI does not
    drive(LW, 0, 6, 0);
    drive(SW, 0, 6, 0);
    settle();
    chk("sw_stall", pc_write, 0);
    drive(SW, 0, 6, 0);
    drive(LW, 0, 6, 0);
    drive(ADDI, 0, 6, 0);
    settle();
    chk("addi_no_stall", pc_write, 1);
    chk("final_count", stall_count, 6);

    settle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Second-generation MIPS pipeline control block.
- Decodes the opcode in ID and owns the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and branch-operand hazards, inserts bubbles, flushes IF on taken branch/jump, and generates forwarding selects.
- Adds ADDI/BNE/J, an illegal-opcode flag, an external freeze and a saturating stall counter.

Parameters:
- OP_W, 6, opcode width
- RA_W, 5, register address width
- CNT_W, 16, stall counter width
- EN_BNE, 1, decode BNE (0: BNE treated as illegal)
- EN_JUMP, 1, decode J (0: J treated as illegal)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- opcode_id  in  OP_W  opcode of the instruction in ID
- rs_id / rt_id / rd_id  in  RA_W each  register fields in ID
- br_eq_id  in  1  ID-stage comparator result, rs==rt
- hold  in  1  external freeze (memory busy)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID update enable
- if_flush  out  1  zero IF/ID next edge
- pc_sel  out  2  00 pc+4, 01 branch target, 10 jump target
- ex_ctrl  out  4  ID/EX {reg_dst, alu_op[1:0], alu_src}
- mem_ctrl  out  3  EX/MEM {branch, mem_read, mem_write}
- wb_ctrl  out  2  MEM/WB {reg_write, mem_to_reg}
- exmem_dest / memwb_dest  out  RA_W each  destination register per stage
- fwd_a / fwd_b  out  2  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- illegal_op  out  1  registered, one-cycle pulse
- stall_count  out  CNT_W  hazard bubbles inserted, saturating

Behaviour:
- Reset: synchronous, active-high. All stage registers, dests, illegal_op and stall_count become 0 on the edge. While reset=1, pc_write=ifid_write=if_flush=0 and pc_sel=00.
- Decode (combinational, ID):
  - R-type 000000: reg_dst=1, alu_op=10, reg_write=1.
  - LW 100011: alu_src=1, mem_read=1, reg_write=1, mem_to_reg=1, alu_op=00.
  - SW 101011: alu_src=1, mem_write=1.
  - BEQ 000100 and BNE 000101: branch=1, alu_op=01.
  - ADDI 001000: alu_src=1, reg_write=1, alu_op=00.
  - J 000010: all bundle bits 0.
  - Any other opcode: all bits 0, and illegal_op pulses the next cycle (only when not held).
- Dest: dest_id = reg_dst ? rd_id : rt_id, carried through all three stages.
- rt counts as a source for R-type, SW, BEQ and BNE only.
- Load-use stall: ID/EX mem_read=1 and idex_dest equals rs_id, or equals rt_id when rt is a source.
- Branch-operand stall: instruction in ID is BEQ/BNE, ID/EX reg_write=1, idex_dest!=0 and idex_dest equals rs_id or rt_id. An LW in EX/MEM matching the same way also stalls.
- On stall: pc_write=0, ifid_write=0, ID/EX loads all zeros (bubble), EX/MEM and MEM/WB advance, stall_count increments (holds at 2^CNT_W-1).
- Branch/jump resolution:
  - Taken = (BEQ & br_eq_id) | (BNE & !br_eq_id), giving pc_sel=01 and if_flush=1.
  - J gives pc_sel=10 and if_flush=1.
  - Zero latency: these outputs are combinational in the same cycle.
- Priority: reset > hold > stall > flush. A stall suppresses flush and pc_sel, so the branch re-resolves once the stall clears.
- Hold=1: every register keeps its value, pc_write=ifid_write=if_flush=0, pc_sel=00, no count, no illegal pulse.
- Forwarding (combinational from stage registers): fwd_a=10 if EX/MEM reg_write, exmem_dest!=0 and exmem_dest==idex_rs. Otherwise 01 if the same holds for MEM/WB. Otherwise 00. fwd_b is the same using idex_rt. EX/MEM wins when both match.
- Register 0 never triggers a stall or a forward.
- Normal pipeline latency: ID decode appears on ex_ctrl after 1 edge, mem_ctrl after 2, wb_ctrl after 3.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants
  - bundle widths and field bit positions for EX/MEM/WB
  - fwd and pc_sel encodings
- Sub-module pipe_hazard_unit: combinational stall and forward logic fed by stage-register fields.
- Decode and the stage registers stay in the top.

Test Plan:
- Reset: hold reset=1 for 2 cycles with opcode_id=000000 -> all outputs 0 and stall_count=0. After release, ex_ctrl=1100 one edge later.
- Load-use: LW rt=5, then ADD rs=5 -> one cycle with pc_write=0, ifid_write=0 and a bubble (ex_ctrl=0000) one edge later. stall_count=1. Next cycle ADD proceeds with fwd_a=01.
- ALU forwarding: ADD rd=3, then SUB rs=3 rt=3 -> fwd_a=fwd_b=10 while SUB is in EX. A write to r0 gives fwd=00.
- Branch: BEQ with br_eq_id=1 -> same cycle if_flush=1, pc_sel=01. BNE with br_eq_id=1 -> if_flush=0, pc_sel=00. J -> pc_sel=10.
- Branch hazard plus hold: ADDI rt=7, then BEQ rs=7 -> stall with if_flush suppressed. Assert hold mid-stall for 3 cycles -> all registers frozen and stall_count unchanged.
- Illegal opcode and saturation: opcode 111111 -> illegal_op=1 for one cycle and bundles 0. With CNT_W=2, 5 stalls -> stall_count=3.
